// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_pkg
// Brief    : Shared SPI definitions (frame size, mode, responder states).
// Revision : 1.0
// ============================================================================
package spi_pkg;

  localparam int SPI_FRAME_SIZE      = 40;
  localparam bit SPI_MSB_FIRST       = 1'b1;
  localparam bit SPI_SAMPLE_ON_RISE  = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_responder_if
// Brief    : SPI pins plus tx/rx word handshake of the SPI responder.
// Revision : 1.0
// ============================================================================
interface spi_responder_if
  import spi_pkg::*;
#(
  parameter int SIZE = SPI_FRAME_SIZE
);

  logic            sclk_in;
  logic            cs_n_in;
  logic            mosi_in;
  logic            miso_out;
  logic [SIZE-1:0] tx_data_in;
  logic            tx_load_in;
  logic            tx_ready_out;
  logic [SIZE-1:0] rx_data_out;
  logic            rx_valid_out;
  logic            frame_error_out;

  modport slave (
    input  sclk_in, cs_n_in, mosi_in, tx_data_in, tx_load_in,
    output miso_out, tx_ready_out, rx_data_out, rx_valid_out, frame_error_out
  );

  modport master (
    output sclk_in, cs_n_in, mosi_in, tx_data_in, tx_load_in,
    input  miso_out, tx_ready_out, rx_data_out, rx_valid_out, frame_error_out
  );

endinterface
`default_nettype wire

// File: rtl/spi_responder_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge
// Brief    : Multi-flop input synchronizer with rise/fall pulse outputs.
// Revision : 1.0
// ============================================================================
module sync_edge
  import spi_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  wire logic internal_clk,
  input  wire logic reset_n_in,
  input  wire logic async_in,
  output logic      rise_out,
  output logic      fall_out
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge internal_clk or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  // Edges come from the last two synchronized samples only.
  assign rise_out =  r_sync[SYNC_STAGES-1] & ~r_prev;
  assign fall_out = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_responder
// Brief    : Oversampling SPI mode-0 slave, MSB first, buffered tx word.
// Revision : 1.0
// ============================================================================
module spi_responder
  import spi_pkg::*;
#(
  parameter int SIZE        = SPI_FRAME_SIZE,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic       internal_clk,
  input  wire logic       reset_n_in,
  spi_responder_if.slave  bus
);

  localparam int                CNT_W       = $clog2(SIZE + 1);
  localparam logic [CNT_W-1:0]  c_frame_len = CNT_W'(SIZE);

  logic                   w_sclk_rise;
  logic                   w_sclk_fall;
  logic                   w_cs_rise;
  logic                   w_cs_fall;
  logic                   w_mosi;
  logic [SIZE-1:0]        w_tx_next;

  logic [SYNC_STAGES-1:0] r_mosi_sync;
  spi_state_t             r_state;
  logic [SIZE-1:0]        r_tx_buf;
  logic [SIZE-1:0]        r_tx_shift;
  logic [SIZE-1:0]        r_rx_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_extra_seen;
  logic                   r_miso;
  logic [SIZE-1:0]        r_rx_data;
  logic                   r_rx_valid;
  logic                   r_frame_err;
  logic                   r_tx_ready;

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b0)
  ) u_sclk_sync (
    .internal_clk (internal_clk),
    .reset_n_in   (reset_n_in),
    .async_in     (bus.sclk_in),
    .rise_out     (w_sclk_rise),
    .fall_out     (w_sclk_fall)
  );

  sync_edge #(
    .SYNC_STAGES (SYNC_STAGES),
    .RESET_VAL   (1'b1)
  ) u_cs_sync (
    .internal_clk (internal_clk),
    .reset_n_in   (reset_n_in),
    .async_in     (bus.cs_n_in),
    .rise_out     (w_cs_rise),
    .fall_out     (w_cs_fall)
  );

  // Same depth as the SCK path so MOSI is aligned with the detected edge.
  always_ff @(posedge internal_clk or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], bus.mosi_in};
    end
  end

  assign w_mosi    = r_mosi_sync[SYNC_STAGES-1];
  assign w_tx_next = bus.tx_load_in ? bus.tx_data_in : r_tx_buf;

  always_ff @(posedge internal_clk or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_state      <= IDLE;
      r_tx_buf     <= '0;
      r_tx_shift   <= '0;
      r_rx_shift   <= '0;
      r_bit_cnt    <= '0;
      r_extra_seen <= 1'b0;
      r_miso       <= 1'b0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_tx_ready   <= 1'b1;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;

      if (bus.tx_load_in) begin
        r_tx_buf   <= bus.tx_data_in;
        r_tx_ready <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_miso <= 1'b0;
          if (w_cs_fall) begin
            r_tx_shift   <= w_tx_next;
            r_miso       <= w_tx_next[SIZE-1];
            r_bit_cnt    <= '0;
            r_extra_seen <= 1'b0;
            // A load in this very cycle refills the buffer it just handed over.
            if (!bus.tx_load_in) begin
              r_tx_ready <= 1'b1;
            end
            r_state <= ACTIVE;
          end
        end

        ACTIVE: begin
          if (r_bit_cnt == c_frame_len) begin
            r_rx_data  <= r_rx_shift;
            r_rx_valid <= 1'b1;
            r_miso     <= 1'b0;
            r_state    <= w_cs_rise ? IDLE : DONE;
          end else if (w_cs_rise) begin
            r_frame_err <= 1'b1;
            r_miso      <= 1'b0;
            r_state     <= IDLE;
          end else begin
            if (w_sclk_rise) begin
              r_rx_shift <= {r_rx_shift[SIZE-2:0], w_mosi};
              r_bit_cnt  <= r_bit_cnt + 1'b1;
            end
            if (w_sclk_fall) begin
              r_tx_shift <= {r_tx_shift[SIZE-2:0], 1'b0};
              r_miso     <= r_tx_shift[SIZE-2];
            end
          end
        end

        DONE: begin
          r_miso <= 1'b0;
          if (w_cs_rise) begin
            r_state <= IDLE;
          end else if (w_sclk_rise && !r_extra_seen) begin
            r_frame_err  <= 1'b1;
            r_extra_seen <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.miso_out        = r_miso;
  assign bus.tx_ready_out    = r_tx_ready;
  assign bus.rx_data_out     = r_rx_data;
  assign bus.rx_valid_out    = r_rx_valid;
  assign bus.frame_error_out = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_responder
// Brief    : Self-checking bench: SIZE=8 and SIZE=40 responders, 8x oversampling.
// Revision : 1.0
// ============================================================================
module tb_spi_responder;

  logic clk;
  logic rst_n;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic sel40;

  int n_vec = 0;
  int n_err = 0;
  int cnt_v8 = 0;
  int cnt_e8 = 0;
  int cnt_v40 = 0;
  int cnt_e40 = 0;

  logic [63:0] q8[$];
  logic [63:0] q40[$];

  spi_responder_if #(.SIZE(8))  if8 ();
  spi_responder_if #(.SIZE(40)) if40 ();

  assign if8.sclk_in  = sclk;
  assign if8.mosi_in  = mosi;
  assign if8.cs_n_in  = sel40 ? 1'b1 : cs_n;
  assign if40.sclk_in = sclk;
  assign if40.mosi_in = mosi;
  assign if40.cs_n_in = sel40 ? cs_n : 1'b1;

  spi_responder #(.SIZE(8), .SYNC_STAGES(2)) u_dut8 (
    .internal_clk (clk),
    .reset_n_in   (rst_n),
    .bus          (if8.slave)
  );

  spi_responder #(.SIZE(40), .SYNC_STAGES(2)) u_dut40 (
    .internal_clk (clk),
    .reset_n_in   (rst_n),
    .bus          (if40.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every rx_valid pulse pops the word pushed when the frame was driven.
  always @(posedge clk) begin
    #1;
    if (if8.rx_valid_out) begin
      cnt_v8++;
      if (q8.size() == 0) check("rx8_unexpected_valid", 64'd1, 64'd0);
      else                check("rx8_data", 64'(if8.rx_data_out), q8.pop_front());
    end
    if (if8.frame_error_out) cnt_e8++;
    if (if40.rx_valid_out) begin
      cnt_v40++;
      if (q40.size() == 0) check("rx40_unexpected_valid", 64'd1, 64'd0);
      else                 check("rx40_data", 64'(if40.rx_data_out), q40.pop_front());
    end
    if (if40.frame_error_out) cnt_e40++;
  end

  task automatic load(input bit to40, input logic [63:0] d);
    if (to40) begin
      if40.tx_data_in = d[39:0];
      if40.tx_load_in = 1'b1;
    end else begin
      if8.tx_data_in = d[7:0];
      if8.tx_load_in = 1'b1;
    end
    @(negedge clk);
    if40.tx_load_in = 1'b0;
    if8.tx_load_in  = 1'b0;
  endtask

  // Initiator model: SCK half period = 4 internal_clk cycles, MISO sampled on SCK rise.
  task automatic spi_frame(input bit to40, input int nbits, input logic [63:0] mosi_word,
                           input bit raise_cs, input int load_bit, input logic [63:0] load_word,
                           output logic [63:0] miso_word);
    miso_word = '0;
    sel40 = to40;
    cs_n  = 1'b0;
    wait_clks(4);
    for (int i = 0; i < nbits; i++) begin
      mosi = mosi_word[nbits-1-i];
      if (i == load_bit) begin
        if8.tx_data_in = load_word[7:0];
        if8.tx_load_in = 1'b1;
        @(negedge clk);
        if8.tx_load_in = 1'b0;
        wait_clks(3);
      end else begin
        wait_clks(4);
      end
      sclk = 1'b1;
      miso_word = {miso_word[62:0], (to40 ? if40.miso_out : if8.miso_out)};
      wait_clks(4);
      sclk = 1'b0;
    end
    wait_clks(4);
    if (raise_cs) begin
      cs_n = 1'b1;
      wait_clks(8);
    end
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] mosi;
  } vec_t;

  vec_t        vecs[5];
  logic [63:0] m;
  int          e8_before;
  int          v8_before;

  initial begin
    vecs[0] = '{tx: 8'hA5, mosi: 8'h3C};
    vecs[1] = '{tx: 8'hFF, mosi: 8'h00};
    vecs[2] = '{tx: 8'h00, mosi: 8'hFF};
    vecs[3] = '{tx: 8'h81, mosi: 8'h7E};
    vecs[4] = '{tx: 8'h5A, mosi: 8'hC3};

    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; sel40 = 1'b0;
    if8.tx_data_in = '0;  if8.tx_load_in = 1'b0;
    if40.tx_data_in = '0; if40.tx_load_in = 1'b0;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(4);

    check("reset_miso",     64'(if8.miso_out),        64'd0);
    check("reset_rx_data",  64'(if8.rx_data_out),     64'd0);
    check("reset_rx_valid", 64'(if8.rx_valid_out),    64'd0);
    check("reset_frame_err",64'(if8.frame_error_out), 64'd0);
    check("reset_tx_ready", 64'(if8.tx_ready_out),    64'd1);
    check("reset_rx40",     64'(if40.rx_data_out),    64'd0);

    // Table-driven 8-bit loopback frames.
    for (int i = 0; i < 5; i++) begin
      load(1'b0, 64'(vecs[i].tx));
      check("tbl_tx_ready_after_load", 64'(if8.tx_ready_out), 64'd0);
      q8.push_back(64'(vecs[i].mosi));
      spi_frame(1'b0, 8, 64'(vecs[i].mosi), 1'b1, -1, '0, m);
      check("tbl_miso_word", m, 64'(vecs[i].tx));
      check("tbl_tx_ready_after_frame", 64'(if8.tx_ready_out), 64'd1);
      check("tbl_valid_count", 64'(cnt_v8), 64'(i + 1));
    end
    check("tbl_no_frame_error", 64'(cnt_e8), 64'd0);

    // Full-width frame.
    load(1'b1, 64'h00C0FFEE1234);
    q40.push_back(64'h00123456789A);
    spi_frame(1'b1, 40, 64'h00123456789A, 1'b1, -1, '0, m);
    sel40 = 1'b0;
    check("w40_miso_word",   m, 64'h00C0FFEE1234);
    check("w40_valid_count", 64'(cnt_v40), 64'd1);
    check("w40_frame_error", 64'(cnt_e40), 64'd0);

    // Abort after 5 bits.
    spi_frame(1'b0, 5, 64'h15, 1'b1, -1, '0, m);
    check("abort_err_count",   64'(cnt_e8), 64'd1);
    check("abort_valid_count", 64'(cnt_v8), 64'd5);
    check("abort_rx_kept",     64'(if8.rx_data_out), 64'(vecs[4].mosi));

    // Overlong: 10 SCK cycles in one frame.
    load(1'b0, 64'hFF);
    q8.push_back(64'h96);
    spi_frame(1'b0, 10, 64'h25B, 1'b1, -1, '0, m);
    check("over_miso_word",   m, 64'h3FC);
    check("over_valid_count", 64'(cnt_v8), 64'd6);
    check("over_err_count",   64'(cnt_e8), 64'd2);

    // Tx buffering: mid-frame load goes to the next frame, no load resends.
    load(1'b0, 64'h11);
    q8.push_back(64'h01);
    spi_frame(1'b0, 8, 64'h01, 1'b1, 3, 64'h22, m);
    check("buf_frame1_miso", m, 64'h11);
    check("buf_ready_low",   64'(if8.tx_ready_out), 64'd0);
    q8.push_back(64'h02);
    spi_frame(1'b0, 8, 64'h02, 1'b1, -1, '0, m);
    check("buf_frame2_miso", m, 64'h22);
    check("buf_ready_high",  64'(if8.tx_ready_out), 64'd1);
    q8.push_back(64'h03);
    spi_frame(1'b0, 8, 64'h03, 1'b1, -1, '0, m);
    check("buf_resend_miso", m, 64'h22);

    // Load in the same cycle the synchronized cs_n fall is acted on.
    if8.tx_data_in = 8'h77;
    cs_n = 1'b0;
    wait_clks(2);
    if8.tx_load_in = 1'b1;
    @(negedge clk);
    if8.tx_load_in = 1'b0;
    q8.push_back(64'h04);
    spi_frame(1'b0, 8, 64'h04, 1'b1, -1, '0, m);
    check("coinc_miso",     m, 64'h77);
    check("coinc_ready_lo", 64'(if8.tx_ready_out), 64'd0);

    // Reset in the middle of a frame.
    e8_before = cnt_e8;
    v8_before = cnt_v8;
    spi_frame(1'b0, 3, 64'h2, 1'b0, -1, '0, m);
    rst_n = 1'b0;
    cs_n  = 1'b1;
    wait_clks(4);
    rst_n = 1'b1;
    wait_clks(4);
    check("rstmid_miso",     64'(if8.miso_out),     64'd0);
    check("rstmid_rx_data",  64'(if8.rx_data_out),  64'd0);
    check("rstmid_tx_ready", 64'(if8.tx_ready_out), 64'd1);
    check("rstmid_no_err",   64'(cnt_e8), 64'(e8_before));
    check("rstmid_no_valid", 64'(cnt_v8), 64'(v8_before));
    q8.push_back(64'h5A);
    spi_frame(1'b0, 8, 64'h5A, 1'b1, -1, '0, m);
    check("rstmid_miso_word", m, 64'h00);
    check("rstmid_valid",     64'(cnt_v8), 64'(v8_before + 1));
    check("rstmid_err_after", 64'(cnt_e8), 64'(e8_before));

    wait_clks(20);
    check("sb8_drained",  64'(q8.size()),  64'd0);
    check("sb40_drained", 64'(q40.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
